// File: rtl/sram_host_seq.sv
// sram_host_seq: serializes host read/write requests onto the sram_top shift/load/w_en/r_en port
// and returns read data (or a timeout error) over a valid/ready response channel.
module sram_host_seq #(
  parameter int ROWS = 16,
  parameter int COLS = 8,
  parameter int RD_TIMEOUT = 16,
  localparam int AW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            wr_done,
  output logic            serial_in,
  output logic            shift,
  output logic            load,
  output logic            w_en,
  output logic            r_en,
  output logic [AW-1:0]   addr,
  input  logic            data_valid,
  input  logic [COLS-1:0] data_out
);
  localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, WRITE, READ, WAIT_RD, RESP} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] wdata_q, wdata_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [COLS-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      bit_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bit_q   <= bit_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // Write word is shifted left each SHIFT cycle so its MSB always drives serial_in
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bit_d     = bit_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wr_done   = 1'b0;
    serial_in = 1'b0;
    shift     = 1'b0;
    load      = 1'b0;
    w_en      = 1'b0;
    r_en      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          bit_d   = '0;
          state_d = req_wr ? SHIFT : READ;
        end
      end
      SHIFT: begin
        shift     = 1'b1;
        serial_in = wdata_q[COLS-1];
        wdata_d   = wdata_q << 1;
        bit_d     = bit_q + 1'b1;
        state_d   = (bit_q == BW'(COLS - 1)) ? LOAD : SHIFT;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        w_en    = 1'b1;
        wr_done = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        r_en    = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (data_valid) begin
          rdata_d = data_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = rsp_ready ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  assign addr      = addr_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_sram_host_seq.sv
// tb_sram_host_seq: randomized bench for sram_host_seq with a serial-in SRAM macro model
// and an array reference of the last word written to each row.
module tb_sram_host_seq;
  localparam int ROWS = 16, COLS = 8, AW = 4, TMO = 16;
  logic clk = 1'b0, arst_n = 1'b1;
  logic req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0, data_valid = 1'b0;
  logic [AW-1:0] req_addr = '0, addr;
  logic [COLS-1:0] req_wdata = '0, data_out = '0, rsp_rdata;
  logic req_ready, rsp_valid, rsp_err, wr_done, serial_in, shift, load, w_en, r_en;
  int checks = 0, errors = 0;
  int rd_delay = -1, dv_cnt = -1;
  logic [AW-1:0] rd_row;
  logic [COLS-1:0] sr, latch;
  logic [COLS-1:0] macro_mem [ROWS];
  logic [COLS-1:0] ref_mem [ROWS];

  sram_host_seq #(.ROWS(ROWS), .COLS(COLS), .RD_TIMEOUT(TMO)) dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .wr_done(wr_done), .serial_in(serial_in),
    .shift(shift), .load(load), .w_en(w_en), .r_en(r_en), .addr(addr),
    .data_valid(data_valid), .data_out(data_out));

  always #5 clk = ~clk;

  // Macro model: shift register, write latch, row array; read data appears rd_delay cycles after r_en
  always @(negedge clk) begin
    data_valid = 1'b0;
    data_out = COLS'($urandom);
    if (shift) sr = {sr[COLS-2:0], serial_in};
    if (load) latch = sr;
    if (w_en) macro_mem[addr] = latch;
    if (r_en) begin
      dv_cnt = rd_delay;
      rd_row = addr;
      if (rd_delay == 0) begin
        data_valid = 1'b1;
        data_out = macro_mem[addr];
      end
    end else if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        data_valid = 1'b1;
        data_out = macro_mem[rd_row];
      end
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      checks++;
      if ($countones({shift, load, w_en, r_en}) > 1 || (!shift && serial_in)) begin
        errors++;
        $display("FAIL strobe_excl got shift=%b load=%b w_en=%b r_en=%b serial_in=%b required one-hot/zero",
                 shift, load, w_en, r_en, serial_in);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready got %b required 1 within 50 cycles", req_ready);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [COLS-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0; req_addr = AW'($urandom); req_wdata = COLS'($urandom);
    for (int k = 0; k < COLS; k++) begin
      checks++;
      if ({shift, serial_in, addr} !== {1'b1, d[COLS-1-k], a}) begin
        errors++;
        $display("FAIL wr_shift[%0d] got shift=%b sin=%b addr=%0d required 1 %b %0d",
                 k, shift, serial_in, addr, d[COLS-1-k], a);
      end
      @(negedge clk);
    end
    checks++;
    if ({load, shift, w_en, req_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL wr_load got load/shift/w_en/rdy=%b required 1000", {load, shift, w_en, req_ready});
    end
    @(negedge clk);
    checks++;
    if ({w_en, wr_done, load, addr} !== {3'b110, a}) begin
      errors++;
      $display("FAIL wr_wen got w_en=%b wr_done=%b load=%b addr=%0d required 1 1 0 %0d",
               w_en, wr_done, load, addr, a);
    end
    @(negedge clk);
    checks++;
    if ({req_ready, w_en, wr_done} !== 3'b100) begin
      errors++;
      $display("FAIL wr_ready got rdy/w_en/wr_done=%b required 100", {req_ready, w_en, wr_done});
    end
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int d, input int hold);
    bit exp_err = (d < 1 || d > TMO);
    logic [COLS-1:0] exp_data = exp_err ? '0 : ref_mem[a];
    int exp_n = exp_err ? TMO + 1 : d + 1;
    int n = 0;
    wait_ready();
    rd_delay = d;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = COLS'($urandom);
    @(negedge clk);
    req_valid = 1'b0; req_addr = AW'($urandom);
    checks++;
    if ({r_en, req_ready, rsp_valid, addr} !== {3'b100, a}) begin
      errors++;
      $display("FAIL rd_ren got r_en=%b rdy=%b rsp_valid=%b addr=%0d required 1 0 0 %0d",
               r_en, req_ready, rsp_valid, addr, a);
    end
    while (n < 40) begin
      rsp_ready = 1'($urandom);
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, exp_err, exp_data} || n != exp_n) begin
      errors++;
      $display("FAIL rd_rsp row %0d delay %0d got valid=%b err=%b data=%h after %0d required 1 %b %h after %0d",
               a, d, rsp_valid, rsp_err, rsp_rdata, n, exp_err, exp_data, exp_n);
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {2'b10, exp_err, exp_data}) begin
        errors++;
        $display("FAIL rd_hold[%0d] got valid=%b rdy=%b err=%b data=%h required 1 0 %b %h",
                 h, rsp_valid, req_ready, rsp_err, rsp_rdata, exp_err, exp_data);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_done got valid=%b rdy=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, wr_done, serial_in, shift, load, w_en, r_en, addr}
        !== {1'b1, {(COLS + AW + 8){1'b0}}}) begin
      errors++;
      $display("FAIL reset got rdy=%b strobes=%b addr=%0d data=%h required rdy=1 rest 0",
               req_ready, {rsp_valid, rsp_err, wr_done, serial_in, shift, load, w_en, r_en}, addr, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_a5();
    do_write(4'd3, 8'hA5);
  endtask

  task automatic test_write_read();
    do_write(4'd7, 8'h3C);
    do_read(4'd7, 2, 0);
  endtask

  task automatic test_timeout();
    do_read(4'd5, -1, 1);
    do_read(4'd7, 16, 0);
    do_read(4'd7, 17, 0);
    do_read(4'd7, 0, 0);
    do_write(4'd5, 8'h5A);
    do_read(4'd5, 1, 0);
  endtask

  task automatic test_backpressure();
    do_read(4'd7, 3, 5);
  endtask

  task automatic test_reset_mid();
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_wdata = 8'h00;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (shift !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift got %b required 1", shift);
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if ({shift, load, w_en, r_en, serial_in, req_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL mid_reset got shift/load/w_en/r_en/sin/rdy=%b required 000001",
               {shift, load, w_en, r_en, serial_in, req_ready});
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release got rdy=%b required 1", req_ready);
    end
    do_write(4'd0, 8'hFF);
    do_read(4'd0, 2, 0);
    do_read(4'd3, 4, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] a = AW'($urandom_range(0, ROWS - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, COLS'($urandom));
      else do_read(a, ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TMO)),
                   int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      macro_mem[r] = '0;
      ref_mem[r] = '0;
    end
    sr = '0;
    latch = '0;
    rd_row = '0;
    test_reset();
    test_write_a5();
    test_write_read();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_host_seq.md
Name: sram_host_seq

Overview:
- Upstream command sequencer for the mixed-signal SRAM macro wrapper (sram_top).
- Accepts parallel read/write requests over a valid/ready handshake and serializes write data onto the macro's shift/serial_in port. It then issues load, w_en or r_en with addr.
- Captures read data when the macro raises data_valid and returns it over a valid/ready response channel, with a timeout error if data_valid never arrives.

Parameters:
- ROWS, 16: SRAM row count; address width AW = $clog2(ROWS).
- COLS, 8: word width in bits; equals the shift-register length in sram_top.
- RD_TIMEOUT, 16: maximum cycles to wait for data_valid after r_en before flagging an error.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- arst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  AW  target row.
- req_wdata  in  COLS  write word.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  COLS  read word.
- rsp_err  out  1  read timed out; rsp_rdata = 0.
- wr_done  out  1  one-cycle pulse when a write completes.
- serial_in  out  1  serial write bit to macro.
- shift  out  1  shift enable to macro.
- load  out  1  transfer shift register into the write latch.
- w_en  out  1  write strobe.
- r_en  out  1  read strobe.
- addr  out  AW  row address to macro.
- data_valid  in  1  macro read data valid.
- data_out  in  COLS  macro read data.

Behaviour:
- Reset (async assert, sync release by flop clocking): state = IDLE, and all outputs are 0 except req_ready = 1. Internal shift, bit and timeout counters are cleared.
- Reset mid-operation aborts the transaction. Outputs return to their reset values in the same cycle arst_n falls.
- Handshake: a request is accepted when req_valid && req_ready. req_ready is high only in IDLE.
  - On acceptance, req_addr, req_wr and req_wdata are registered.
  - addr is held at the registered value until return to IDLE.
- Write path:
  - SHIFT: COLS cycles with shift = 1. serial_in = word bit [COLS-1-k] in cycle k, i.e. MSB first.
  - LOAD: one cycle with load = 1 and shift = 0.
  - WRITE: one cycle with w_en = 1. wr_done pulses in the same cycle.
  - Then IDLE.
  - Accept-to-w_en latency = COLS+2 cycles; request-to-next-req_ready = COLS+3 cycles.
- Read path:
  - READ: one cycle with r_en = 1.
  - WAIT_RD: timeout counter increments each cycle.
    - data_valid = 1 → capture data_out into rsp_rdata with rsp_err = 0, go to RESP.
    - Counter reaches RD_TIMEOUT without data_valid → rsp_rdata = 0, rsp_err = 1, go to RESP.
  - A data_valid arriving in the same cycle as r_en is ignored; the macro has at least 1 cycle latency.
- RESP: rsp_valid held high, with rsp_rdata and rsp_err stable, until rsp_ready. Then IDLE.
  - rsp_ready while rsp_valid is low has no effect.
  - data_valid outside WAIT_RD is ignored.
- shift, load, w_en and r_en are mutually exclusive (one-hot or all zero) in every cycle.
- serial_in = 0 whenever shift = 0.
- Back-to-back requests: a new request is accepted in the cycle after return to IDLE. There is no pipelining.

Test Plan:
- Reset then write addr 3, data 8'hA5 → shift high 8 cycles with serial_in 1,0,1,0,0,1,0,1; then load for 1 cycle; then w_en with addr = 3 and wr_done. req_ready returns 11 cycles after accept.
- Write 8'h3C to addr 7, then read addr 7 with the macro model returning data_valid 2 cycles after r_en → rsp_valid with rsp_rdata = 8'h3C and rsp_err = 0.
- Read with data_valid never asserted → after 16 cycles rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. The next request is accepted normally.
- Response backpressure: hold rsp_ready = 0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready = 0 throughout. Accepted on the first rsp_ready cycle.
- Assert arst_n = 0 during SHIFT (bit 4) → all macro strobes drop immediately and req_ready = 1 after release. A subsequent write of 8'hFF to addr 0 completes correctly.
- Random 200 reads/writes over all ROWS against a reference model → every read matches the last write, and the strobe exclusivity assertion never fires.
